// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks and publishes the count with a one-cycle valid pulse.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   sat;
  logic                   sat_next;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_prev;

  // Synchronizer and edge-detect history; s_prev tracks s every cycle,
  // so a level already high when the gate opens never looks like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev <= s;
    end
  end

  // Saturating edge count including this cycle's rise.
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_next = 1'b1;
      else                     cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  // The result is registered on the final gate edge so freq/ovf/valid are
  // all visible during the LATCH cycle, including a rise in that last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (en) begin
            state <= GATE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            edge_cnt <= cnt_next;
            sat      <= sat_next;
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (gate_cnt == GATE_LAST) begin
              state <= LATCH;
              freq  <= cnt_next;
              ovf   <= sat_next;
              valid <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (en) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two widths share one stimulus; an edge-counting model
// predicts every output each cycle, with directed scenarios pinning literals.
module tb_freq_meter;

  localparam int unsigned GATE = 1000;
  localparam int unsigned SYNC = 2;
  localparam longint MAX26 = (64'd1 << 26) - 1;
  localparam longint MAX6  = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        en;
  logic [25:0] freq;
  logic        valid, ovf, busy;
  logic [5:0]  freq6;
  logic        valid6, ovf6, busy6;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(26), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq(freq), .valid(valid), .ovf(ovf), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(6), .SYNC_STAGES(SYNC)) dut6 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq(freq6), .valid(valid6), .ovf(ovf6), .busy(busy6)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_range(input string nm, input longint act, input longint lo, input longint hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
  endtask

  // Square-wave generator: period and high time in clk cycles, or a held level.
  int period = 10;
  int hi_len = 5;
  int ph = 0;
  bit hold = 1'b0;
  bit hold_val = 1'b0;
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (hold) sig_in = hold_val;
      else begin
        ph = (ph + 1) % period;
        sig_in = (ph < hi_len);
      end
    end
  end

  // Model: pos = -1 idle, 0 arm, 1..GATE gate cycles, GATE+1 result cycle.
  // Rises are counted unbounded; saturation is applied when published.
  logic   hist [0:SYNC+1];
  int     pos = -1;
  longint cnt = 0;
  longint exp_freq = 0, exp_freq6 = 0;
  bit     exp_ovf = 0, exp_ovf6 = 0, exp_valid = 0, exp_busy = 0;

  initial for (int k = 0; k <= SYNC + 1; k++) hist[k] = 1'b0;

  always @(posedge clk) begin
    bit r;
    r = hist[SYNC-1] & ~hist[SYNC];
    if (rst) begin
      pos = -1; cnt = 0;
      exp_freq = 0; exp_freq6 = 0; exp_ovf = 0; exp_ovf6 = 0; exp_valid = 0;
    end else begin
      exp_valid = 0;
      if (pos < 0 || pos == int'(GATE) + 1) pos = en ? 0 : -1;
      else if (!en) pos = -1;
      else begin
        if (pos == 0) cnt = 0;
        else cnt += longint'(r);
        pos++;
        if (pos == int'(GATE) + 1) begin
          exp_valid = 1;
          exp_freq  = (cnt > MAX26) ? MAX26 : cnt;
          exp_ovf   = (cnt > MAX26);
          exp_freq6 = (cnt > MAX6) ? MAX6 : cnt;
          exp_ovf6  = (cnt > MAX6);
        end
      end
    end
    exp_busy = (pos >= 0);
    for (int k = SYNC + 1; k > 0; k--) hist[k] = rst ? 1'b0 : hist[k-1];
    hist[0] = rst ? 1'b0 : sig_in;
    cyc++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out26 {freq,valid,ovf,busy}", longint'({freq, valid, ovf, busy}),
          longint'({exp_freq[25:0], exp_valid, exp_ovf, exp_busy}));
      chk("out6 {freq,valid,ovf,busy}", longint'({freq6, valid6, ovf6, busy6}),
          longint'({exp_freq6[5:0], exp_valid, exp_ovf6, exp_busy}));
    end
  end

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 3000);
    if (!valid) begin
      total++;
      $display("FAIL %s: no valid within %0d cycles", nm, n);
    end
  endtask

  int c0;
  int vcyc [5];
  bit saw;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("reset_freq", longint'(freq), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_valid", longint'(valid), 0);
    rst = 1'b0;

    // Period 10 -> 100 edges per gate; first valid 1002 cycles after en.
    period = 10; hi_len = 5;
    repeat (20) @(negedge clk);
    en = 1'b1; c0 = cyc;
    wait_valid("t1_valid");
    chk("t1_latency", longint'(cyc - c0), 1002);
    chk("t1_freq", longint'(freq), 100);
    chk("t1_model_freq", exp_freq, 100);
    chk("t1_ovf", longint'(ovf), 0);
    chk("t1_freq6_sat", longint'(freq6), 63);
    chk("t1_ovf6", longint'(ovf6), 1);

    // Abort the second gate halfway: no publish, freq keeps 100.
    repeat (502) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_busy_low", longint'(busy), 0);
    saw = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (valid) saw = 1'b1;
    end
    chk("t4_no_valid", longint'(saw), 0);
    chk("t4_freq_kept", longint'(freq), 100);

    // Level already high before the gate is not an edge.
    hold = 1'b1; hold_val = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_valid("t2_valid");
    chk("t2_freq", longint'(freq), 0);
    chk("t2_ovf", longint'(ovf), 0);
    chk("t2_model_freq", exp_freq, 0);
    en = 1'b0;
    @(negedge clk);
    chk("t2_latch_en0_valid", longint'(valid), 0);
    chk("t2_latch_en0_busy", longint'(busy), 0);
    hold = 1'b0;

    // Saturation on the narrow instance, then recovery.
    period = 4; hi_len = 2;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_valid("t3a_valid");
    chk("t3a_freq6", longint'(freq6), 63);
    chk("t3a_ovf6", longint'(ovf6), 1);
    chk("t3a_freq26", longint'(freq), 250);
    chk("t3a_ovf26", longint'(ovf), 0);
    en = 1'b0;
    repeat (5) @(negedge clk);
    period = 100; hi_len = 50;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_valid("t3b_valid");
    chk("t3b_freq6", longint'(freq6), 10);
    chk("t3b_ovf6", longint'(ovf6), 0);

    // Reset mid-gate clears everything.
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_freq", longint'(freq), 0);
    chk("t5_valid", longint'(valid), 0);
    chk("t5_ovf6", longint'(ovf6), 0);
    chk("t5_busy", longint'(busy), 0);
    rst = 1'b0;

    // Continuous run: five results, 1002 cycles apart, about 50 edges each.
    en = 1'b0;
    period = 20; hi_len = 10;
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("t6_valid");
      vcyc[i] = cyc;
      chk_range("t6_freq", longint'(freq), 49, 51);
      if (i > 0) chk("t6_spacing", longint'(vcyc[i] - vcyc[i-1]), 1002);
    end
    en = 1'b0;
    repeat (5) @(negedge clk);

    // Random periods, duty, held levels, en windows and resets.
    for (int it = 0; it < 20; it++) begin
      period   = int'($urandom_range(3, 60));
      hi_len   = int'($urandom_range(1, 32'(period - 1)));
      hold     = ($urandom_range(0, 7) == 0);
      hold_val = 1'($urandom);
      en = 1'b1;
      repeat ($urandom_range(1, 2600)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      en = 1'b0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
